// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, types and helpers for the VGA timing generator.
// Holds the 640x480@60 default timing, the RGB332 field positions, the
// per-stage flag bundle carried down the fetch-to-display delay line, and
// the MSB-first bit-replication colour expansion.
package vga_pkg;

    // 640x480@60 default timing (25.175 MHz pixel clock)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // RGB332 field positions: {R[7:5], G[4:2], B[1:0]}
    localparam int RGB332_R_MSB = 7;
    localparam int RGB332_G_MSB = 4;
    localparam int RGB332_B_MSB = 1;

    // Raster flags produced at the fetch stage and delayed to the display stage.
    // All-zero means "blanked, no sync, not a line/frame start", which is what
    // a cleared delay line must look like.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic line;
        logic frame;
    } vga_flags_t;

    // Bit idx of the out_w-wide MSB-first replication of the low src_w bits
    // of src. Output MSB takes the source MSB, then the pattern repeats.
    function automatic logic replicate_bit(input logic [2:0] src, input int src_w,
                                           input int out_w, input int idx);
        int pos;
        pos = (out_w - 1 - idx) % src_w;
        return src[src_w - 1 - pos];
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel fetch bus between the timing generator (master)
// and the frame buffer / pixel source (slave).
// Handshake: pix_req has no ready. Whenever pix_req is high, x_out/y_out name
// a visible pixel and the slave must present that pixel on pixel_in exactly
// FETCH_LAT cycles later; pixel_in is sampled every cycle, no backpressure.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_req;
    logic [CNT_W-1:0] x_out;
    logic [CNT_W-1:0] y_out;
    logic [7:0]       pixel_in;

    modport master (output pix_req, output x_out, output y_out, input pixel_in);
    modport slave  (input pix_req, input x_out, input y_out, output pixel_in);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter, 0..TOTAL-1, advancing when inc
// is high. wrap flags the cycle in which the counter rolls back to zero.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;

    assign wrap  = inc && (count_q == LAST);
    assign count = count_q;

    // Next count: hold, step, or roll over at the end of the axis
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing and pixel output stage.
// Fetch stage is combinational from the h/v counters and issues pixel
// requests FETCH_LAT cycles ahead; the raster flags ride a FETCH_LAT-deep
// delay line to meet pixel_in, then everything is registered together so
// colour, sync and blank leave the block from the same flop stage.
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_en input and
// an 8-bar colour test pattern, latched per frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 10,
    parameter int FETCH_LAT = 1,
    parameter int OUT_W     = 10
) (
    input  logic             clk_pix,
    input  logic             Reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_en,
`endif
    vga_timing_gen_if.master fetch,
    output logic             frame_start,
    output logic             line_start,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK,
    output logic             VGA_SYNC,
    output logic             VGA_CLK
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             origin_q, origin_d;
    vga_flags_t       fetch_flags, disp_flags;

    logic [OUT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             blank_q, blank_d, fs_q, fs_d, ls_q, ls_d;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk   (clk_pix),
        .Reset (Reset),
        .inc   (1'b1),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk   (clk_pix),
        .Reset (Reset),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    // The cycle after a frame wrap is (0,0); reset also lands on (0,0)
    assign origin_d = v_wrap;

    // Origin marker register; set on reset because the counters clear to (0,0)
    always_ff @(posedge clk_pix or negedge Reset) begin
        if (!Reset) begin
            origin_q <= 1'b1;
        end else begin
            origin_q <= origin_d;
        end
    end

    // Fetch-stage raster decode from the current counter position
    always_comb begin
        fetch_flags        = '0;
        fetch_flags.active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
        fetch_flags.hsync  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
        fetch_flags.vsync  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
        fetch_flags.line   = (h_cnt == '0);
        fetch_flags.frame  = origin_q;
    end

    assign fetch.pix_req = fetch_flags.active;
    assign fetch.x_out   = fetch_flags.active ? h_cnt : '0;
    assign fetch.y_out   = fetch_flags.active ? v_cnt : '0;

    generate
        if (FETCH_LAT == 0) begin : g_no_dly
            assign disp_flags = fetch_flags;
        end else begin : g_dly
            vga_flags_t dly_q [FETCH_LAT];
            vga_flags_t dly_d [FETCH_LAT];

            // Shift the flags one stage per cycle so they meet pixel_in
            always_comb begin
                dly_d[0] = fetch_flags;
                for (int i = 1; i < FETCH_LAT; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            // Delay-line registers, all cleared to "blanked, no sync"
            always_ff @(posedge clk_pix or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < FETCH_LAT; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign disp_flags = dly_q[FETCH_LAT-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic             test_mode_q, test_mode_d, pattern_on;
    logic [2:0]       bar_q, bar_d, bar_cur;
    logic [CNT_W-1:0] bar_px_q, bar_px_d, bar_px_cur;

    // Take test_en as the first pixel of a frame is displayed; track which bar
    // the display-stage pixel falls in, restarting at every line start
    always_comb begin
        pattern_on  = disp_flags.frame ? test_en : test_mode_q;
        test_mode_d = pattern_on;
        bar_cur     = disp_flags.line ? 3'd0 : bar_q;
        bar_px_cur  = disp_flags.line ? '0 : bar_px_q;
        if (bar_px_cur == CNT_W'(BAR_W - 1)) begin
            bar_px_d = '0;
            bar_d    = bar_cur + 3'd1;
        end else begin
            bar_px_d = bar_px_cur + 1'b1;
            bar_d    = bar_cur;
        end
    end

    // Test-pattern mode and bar position registers
    always_ff @(posedge clk_pix or negedge Reset) begin
        if (!Reset) begin
            test_mode_q <= 1'b0;
            bar_q       <= '0;
            bar_px_q    <= '0;
        end else begin
            test_mode_q <= test_mode_d;
            bar_q       <= bar_d;
            bar_px_q    <= bar_px_d;
        end
    end
`endif

    // Display-stage colour: expand RGB332 inside the visible area, black elsewhere
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (disp_flags.active) begin
            for (int i = 0; i < OUT_W; i++) begin
                r_d[i] = replicate_bit(fetch.pixel_in[RGB332_R_MSB -: 3], 3, OUT_W, i);
                g_d[i] = replicate_bit(fetch.pixel_in[RGB332_G_MSB -: 3], 3, OUT_W, i);
                b_d[i] = replicate_bit({1'b0, fetch.pixel_in[RGB332_B_MSB -: 2]}, 2, OUT_W, i);
            end
`ifdef VGA_TEST_PATTERN_EN
            if (pattern_on) begin
                r_d = {OUT_W{bar_cur[2]}};
                g_d = {OUT_W{bar_cur[1]}};
                b_d = {OUT_W{bar_cur[0]}};
            end
`endif
        end
    end

    // Display-stage sync, blank and start markers
    always_comb begin
        hs_d    = disp_flags.hsync ? HS_POL : ~HS_POL;
        vs_d    = disp_flags.vsync ? VS_POL : ~VS_POL;
        blank_d = disp_flags.active;
        fs_d    = disp_flags.frame;
        ls_d    = disp_flags.line;
    end

    // Output register stage shared by colour, sync and blank
    always_ff @(posedge clk_pix or negedge Reset) begin
        if (!Reset) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign VGA_SYNC    = 1'b0;
    assign VGA_CLK     = clk_pix;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen on a shrunken raster
// (24x10 total, 16x6 visible) with FETCH_LAT=3, active-low HS and active-high VS.
// Expected outputs come from a cycle-index model of the raster and a random
// frame buffer that also feeds the pixel source.
module tb_vga_timing_gen;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int F   = HT * VT;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;
    localparam int CW  = 6;
    localparam int L   = 3;
    localparam int OW  = 10;
    localparam int EXP_W = 5 + 3 * OW;
    localparam int FW    = 1 + 2 * CW;

    logic          clk_pix;
    logic          Reset;
    logic          test_en;
    logic          frame_start, line_start;
    logic [OW-1:0] vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

    vga_timing_gen_if #(.CNT_W(CW)) fb_if ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL),
        .CNT_W(CW), .FETCH_LAT(L), .OUT_W(OW)
    ) dut (
        .clk_pix     (clk_pix),
        .Reset       (Reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_en     (test_en),
`endif
        .fetch       (fb_if),
        .frame_start (frame_start),
        .line_start  (line_start),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_BLANK   (vga_blank),
        .VGA_SYNC    (vga_sync),
        .VGA_CLK     (vga_clk)
    );

    int checks = 0;
    int passes = 0;
    int k = 0;
    bit te_lat = 1'b0;
    logic [7:0]       fb [VA][HA];
    logic [FW-1:0]    hist [L+1];
    logic [EXP_W-1:0] exp_q [$];

    // Clock and cycle index since reset release
    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    always @(posedge clk_pix or negedge Reset) begin
        if (!Reset) k <= 0;
        else        k <= k + 1;
    end

    // Pixel source driver: answers each request exactly L cycles later
    initial begin
        logic          req_r;
        logic [CW-1:0] xr, yr;
        fb_if.pixel_in = 8'h00;
        forever begin
            @(posedge clk_pix);
            #1;
            for (int i = L; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {fb_if.pix_req, fb_if.x_out, fb_if.y_out};
            req_r = hist[L][2*CW];
            xr    = hist[L][2*CW-1:CW];
            yr    = hist[L][CW-1:0];
            if (req_r === 1'b1 && xr < HA && yr < VA) fb_if.pixel_in = fb[yr][xr];
            else                                      fb_if.pixel_in = 8'($urandom);
        end
    end

    function automatic logic [OW-1:0] exp3(input logic [2:0] s);
        logic [11:0] t;
        t = {s, s, s, s};
        return t[11:2];
    endfunction

    function automatic logic [OW-1:0] exp2(input logic [1:0] s);
        return {5{s}};
    endfunction

    // Display outputs expected in cycle kk after reset release
    function automatic logic [EXP_W-1:0] model_out(input int kk, input bit tm);
        int q, h, v;
        bit act;
        logic hs, vs;
        logic [OW-1:0] r, g, b;
        logic [7:0] px;
        logic [2:0] barv;
        r = '0; g = '0; b = '0;
        if (kk < L + 1) return {~HS_POL, ~VS_POL, 3'b000, {(3*OW){1'b0}}};
        q = (kk - (L + 1)) % F;
        h = q % HT;
        v = q / HT;
        act = (h < HA) && (v < VA);
        hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HS_POL : ~HS_POL;
        vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VS_POL : ~VS_POL;
        if (act) begin
            if (tm) begin
                barv = 3'(h / (HA / 8));
                r = {OW{barv[2]}};
                g = {OW{barv[1]}};
                b = {OW{barv[0]}};
            end else begin
                px = fb[v][h];
                r = exp3(px[7:5]);
                g = exp3(px[4:2]);
                b = exp2(px[1:0]);
            end
        end
        return {hs, vs, act, (q == 0), (h == 0), r, g, b};
    endfunction

    // Fetch request expected in cycle kk
    function automatic logic [FW-1:0] model_fetch(input int kk);
        int p, h, v;
        bit req;
        p = kk % F;
        h = p % HT;
        v = p / HT;
        req = (h < HA) && (v < VA);
        return {req, req ? CW'(h) : CW'(0), req ? CW'(v) : CW'(0)};
    endfunction

    task automatic test_reset;
        logic [EXP_W-1:0] got;
        @(negedge clk_pix);
        got = {vga_hs, vga_vs, vga_blank, frame_start, line_start, vga_r, vga_g, vga_b};
        checks++;
        if (got !== model_out(0, 1'b0)) $display("FAIL reset_out got=%h exp=%h", got, model_out(0, 1'b0));
        else passes++;
        checks++;
        if ({fb_if.pix_req, fb_if.x_out, fb_if.y_out} !== {1'b1, CW'(0), CW'(0)})
            $display("FAIL reset_fetch got=%h exp=%h", {fb_if.pix_req, fb_if.x_out, fb_if.y_out}, {1'b1, CW'(0), CW'(0)});
        else passes++;
        checks++;
        if (vga_sync !== 1'b0) $display("FAIL vga_sync got=%b exp=0", vga_sync);
        else passes++;
        checks++;
        if (vga_clk !== clk_pix) $display("FAIL vga_clk got=%b exp=%b", vga_clk, clk_pix);
        else passes++;
        Reset = 1'b1;
    endtask

    task automatic test_raster(input int ncyc);
        int last_fs, q;
        logic [EXP_W-1:0] got, exp_w;
        logic [FW-1:0] fgot, fexp;
        last_fs = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_pix);
            q = k - (L + 1);
            if (q >= 0 && q % F == 0) te_lat = test_en;
            exp_q.push_back(model_out(k, te_lat));
            exp_w = exp_q.pop_front();
            got = {vga_hs, vga_vs, vga_blank, frame_start, line_start, vga_r, vga_g, vga_b};
            checks++;
            if (got !== exp_w) $display("FAIL display k=%0d got=%h exp=%h", k, got, exp_w);
            else passes++;
            fexp = model_fetch(k);
            fgot = {fb_if.pix_req, fb_if.x_out, fb_if.y_out};
            checks++;
            if (fgot !== fexp) $display("FAIL fetch k=%0d got=%h exp=%h", k, fgot, fexp);
            else passes++;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (k - last_fs !== F) $display("FAIL frame_period got=%0d exp=%0d", k - last_fs, F);
                    else passes++;
                end
                last_fs = k;
            end
        end
    endtask

    // Advance to the display-stage mid-frame point, keeping the frame latch model current
    task automatic wait_mid_frame;
        int n, q;
        n = 0;
        do begin
            @(negedge clk_pix);
            q = k - (L + 1);
            if (q >= 0 && q % F == 0) te_lat = test_en;
            n++;
        end while (!(q >= 0 && q % F == F / 2) && n < 2 * F);
        checks++;
        if (n >= 2 * F) $display("FAIL mid_frame_wait got=%0d cycles exp<%0d", n, 2 * F);
        else passes++;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern;
        wait_mid_frame();
        test_en = 1'b1;
        test_raster(2 * F);
        wait_mid_frame();
        test_en = 1'b0;
        test_raster(F + F / 2);
    endtask
`endif

    task automatic test_mid_reset;
        int n;
        bit seen;
        logic [EXP_W-1:0] got;
        n = 0;
        while ((k % F) != 3 * HT + 10 && n < 2 * F) begin
            @(negedge clk_pix);
            n++;
        end
        checks++;
        if (n >= 2 * F) $display("FAIL mid_reset_wait got=%0d cycles exp<%0d", n, 2 * F);
        else passes++;
        Reset = 1'b0;
        #1;
        got = {vga_hs, vga_vs, vga_blank, frame_start, line_start, vga_r, vga_g, vga_b};
        checks++;
        if (got !== model_out(0, 1'b0)) $display("FAIL mid_reset_out got=%h exp=%h", got, model_out(0, 1'b0));
        else passes++;
        checks++;
        if ({fb_if.pix_req, fb_if.x_out, fb_if.y_out} !== {1'b1, CW'(0), CW'(0)})
            $display("FAIL mid_reset_fetch got=%h exp=%h", {fb_if.pix_req, fb_if.x_out, fb_if.y_out}, {1'b1, CW'(0), CW'(0)});
        else passes++;
        @(negedge clk_pix);
        Reset = 1'b1;
        te_lat = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk_pix);
            n++;
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != L + 1) $display("FAIL frame_start_after_reset got=%0d cycles exp=%0d", n, L + 1);
        else passes++;
    endtask

    initial begin
        Reset   = 1'b0;
        test_en = 1'b0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                fb[y][x] = 8'($urandom_range(0, 255));
        fb[0][0] = 8'hFF;
        fb[0][1] = 8'h00;
        fb[0][2] = 8'b1000_0010;
        fb[1][15] = 8'hFF;
        repeat (3) @(negedge clk_pix);
        test_reset();
        test_raster(2 * F + 20);
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        test_mid_reset();
        test_raster(2 * F);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
